// File: rtl/tl_intersection_ctrl.sv
// tl_intersection_ctrl
//   Phase controller for a two-road intersection with a pedestrian crossing.
//   The main road rests in green. The side road and the pedestrian crossing are
//   served on request. Every phase has a minimum, maximum, yellow and all-red
//   clearance time.
// Ports:
//   clk, rst_n   clock; asynchronous active-low reset
//   side_req     side-road vehicle sensor (level)
//   ped_req      pedestrian button; any high sample is latched
//   main_lamp    main road {red, yellow, green}, one-hot
//   side_lamp    side road {red, yellow, green}, one-hot
//   walk         pedestrian walk lamp
//   ped_ack      one-cycle pulse on the first cycle of the walk phase
//   state        current phase, for debug
module tl_intersection_ctrl #(
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 16,
  parameter int YELLOW    = 3,
  parameter int ALLRED    = 2,
  parameter int WALK      = 6,
  parameter int CW        = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [2:0] main_lamp,
  output logic [2:0] side_lamp,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] state
);

  localparam logic [2:0] MAIN_G = 3'd0;
  localparam logic [2:0] MAIN_Y = 3'd1;
  localparam logic [2:0] CLR_M  = 3'd2;
  localparam logic [2:0] SIDE_G = 3'd3;
  localparam logic [2:0] SIDE_Y = 3'd4;
  localparam logic [2:0] CLR_S  = 3'd5;
  localparam logic [2:0] WALK_P = 3'd6;
  localparam logic [2:0] CLR_P  = 3'd7;

  // Last-cycle timer values for each timed phase
  localparam logic [CW-1:0] T_GMIN = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] T_GMAX = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] T_YEL  = CW'(YELLOW - 1);
  localparam logic [CW-1:0] T_CLR  = CW'(ALLRED - 1);
  localparam logic [CW-1:0] T_WALK = CW'(WALK - 1);

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  logic [2:0]    nxt;
  logic [CW-1:0] tmr;
  logic          side_pend, ped_pend;
  logic          change;

  always_comb begin
    nxt = state;
    case (state)
      MAIN_G: if (tmr >= T_GMIN && (side_pend || ped_pend)) nxt = MAIN_Y;
      MAIN_Y: if (tmr == T_YEL) nxt = CLR_M;
      CLR_M:  if (tmr == T_CLR) nxt = side_pend ? SIDE_G :
                                      ped_pend  ? WALK_P : MAIN_G;
      SIDE_G: if (tmr == T_GMAX || (tmr >= T_GMIN && !side_req)) nxt = SIDE_Y;
      SIDE_Y: if (tmr == T_YEL) nxt = CLR_S;
      CLR_S:  if (tmr == T_CLR) nxt = ped_pend ? WALK_P : MAIN_G;
      WALK_P: if (tmr == T_WALK) nxt = CLR_P;
      CLR_P:  if (tmr == T_CLR) nxt = MAIN_G;
      default: nxt = CLR_P;
    endcase
  end

  assign change = (nxt != state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLR_P;
      tmr       <= '0;
      side_pend <= 1'b0;
      ped_pend  <= 1'b0;
      ped_ack   <= 1'b0;
    end else begin
      state <= nxt;
      if (change)    tmr <= '0;
      else if (!(&tmr)) tmr <= tmr + 1'b1;   // saturate at all-ones
      // Clearing on entry to the serving phase beats a same-cycle request.
      side_pend <= (change && nxt == SIDE_G) ? 1'b0 : (side_pend | side_req);
      ped_pend  <= (change && nxt == WALK_P) ? 1'b0 : (ped_pend  | ped_req);
      ped_ack   <= change && (nxt == WALK_P);
    end
  end

  // Moore lamp decode: anything other than this road's green/yellow is red
  always_comb begin
    main_lamp = L_RED;
    side_lamp = L_RED;
    case (state)
      MAIN_G:  main_lamp = L_GRN;
      MAIN_Y:  main_lamp = L_YEL;
      SIDE_G:  side_lamp = L_GRN;
      SIDE_Y:  side_lamp = L_YEL;
      default: ;
    endcase
  end

  assign walk = (state == WALK_P);

endmodule
